// File: rtl/assist_mode_ctrl_if.sv
// Button inputs, scale table and mode outputs of the assist mode selector.
// The master side drives buttons and table; the slave side reports mode, scale and change pulse.
interface assist_mode_ctrl_if #(
  parameter int NUM_MODES = 4,
  parameter int SCALE_W   = 3
);
  localparam int MW = $clog2(NUM_MODES);

  logic                         btn_up;
  logic                         btn_dn;
  logic [NUM_MODES*SCALE_W-1:0] scale_tbl;
  logic [MW-1:0]                mode;
  logic [SCALE_W-1:0]           scale;
  logic                         mode_chg;

  modport master (
    output btn_up, btn_dn, scale_tbl,
    input  mode, scale, mode_chg
  );

  modport slave (
    input  btn_up, btn_dn, scale_tbl,
    output mode, scale, mode_chg
  );
endinterface

// File: rtl/assist_mode_ctrl.sv
// Pedal-assist mode selector: synchronised, debounced up/down buttons step the mode on release.
// Mode moves DEB_CYC+3 cycles after a raw release; no backpressure, outputs are level-sampled.
module assist_mode_ctrl #(
  parameter int NUM_MODES = 4,
  parameter int SCALE_W   = 3,
  parameter int RST_MODE  = 2,
  parameter int DEB_CYC   = 50000,
  parameter int LONG_CYC  = 1000000,
  parameter bit WRAP      = 1'b1
) (
  input logic clk,
  input logic rst_n,
  assist_mode_ctrl_if.slave bus
);
  localparam int MW = $clog2(NUM_MODES);
  localparam int DW = $clog2(DEB_CYC);
  localparam int HW = $clog2(LONG_CYC + 1);

  localparam logic [MW-1:0] MODE_MAX = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0] MODE_RST = MW'(RST_MODE);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 1);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    s;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [1:0]    rel;
  logic [DW-1:0] cnt [2];

  logic [HW-1:0] hold;
  logic          long_evt;
  logic          long_seen;
  logic          rel_up;
  logic          rel_dn;
  logic          rel_dn_act;

  logic [MW-1:0] mode_r;
  logic [MW-1:0] mode_nxt;
  logic          chg_r;

  assign raw = {bus.btn_dn, bus.btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (s[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  assign rel        = deb_q & ~deb;
  assign rel_up     = rel[0];
  assign rel_dn     = rel[1];
  // The release that ends a long press has already done its job.
  assign rel_dn_act = rel_dn & ~long_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      long_evt  <= 1'b0;
      long_seen <= 1'b0;
    end else begin
      long_evt <= deb[1] && (hold == HOLD_PRE);
      if (!deb[1]) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + HW'(1);
      end
      if (deb[1] && (hold == HOLD_PRE)) begin
        long_seen <= 1'b1;
      end else if (rel_dn) begin
        long_seen <= 1'b0;
      end
    end
  end

  always_comb begin
    mode_nxt = mode_r;
    if (long_evt) begin
      mode_nxt = '0;
    end else if (rel_up && rel_dn_act) begin
      mode_nxt = mode_r;
    end else if (rel_up) begin
      if (mode_r == MODE_MAX) mode_nxt = WRAP ? '0 : mode_r;
      else                    mode_nxt = mode_r + MW'(1);
    end else if (rel_dn_act) begin
      if (mode_r == '0) mode_nxt = WRAP ? MODE_MAX : mode_r;
      else              mode_nxt = mode_r - MW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_RST;
      chg_r  <= 1'b0;
    end else begin
      mode_r <= mode_nxt;
      chg_r  <= (mode_nxt != mode_r);
    end
  end

  always_comb begin
    bus.scale = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_r == MW'(m)) bus.scale = bus.scale_tbl[m*SCALE_W +: SCALE_W];
    end
  end

  assign bus.mode     = mode_r;
  assign bus.mode_chg = chg_r;
endmodule

// File: tb/tb_assist_mode_ctrl.sv
// Directed bench: one wrapping and one saturating assist_mode_ctrl share the same button stimulus.
module tb_assist_mode_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] ew;
  logic [1:0] es;

  assist_mode_ctrl_if #(.NUM_MODES(4), .SCALE_W(3)) ifw ();
  assist_mode_ctrl_if #(.NUM_MODES(4), .SCALE_W(3)) ifs ();

  assign ifw.btn_up    = btn_up;
  assign ifw.btn_dn    = btn_dn;
  assign ifw.scale_tbl = {3'd7, 3'd5, 3'd3, 3'd0};
  assign ifs.btn_up    = btn_up;
  assign ifs.btn_dn    = btn_dn;
  assign ifs.scale_tbl = {3'd7, 3'd5, 3'd3, 3'd0};

  assist_mode_ctrl #(.NUM_MODES(4), .SCALE_W(3), .RST_MODE(2), .DEB_CYC(4),
                     .LONG_CYC(20), .WRAP(1'b1))
    dut_wrap (.clk(clk), .rst_n(rst_n), .bus(ifw));

  assist_mode_ctrl #(.NUM_MODES(4), .SCALE_W(3), .RST_MODE(2), .DEB_CYC(4),
                     .LONG_CYC(20), .WRAP(1'b0))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(ifs));

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_scale(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd0;
      2'd1:    return 3'd3;
      2'd2:    return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic cw, input logic cs);
    checks++;
    assert ({ifw.mode, ifw.scale, ifw.mode_chg} === {ew, exp_scale(ew), cw}) else begin
      errors++;
      $error("FAIL %s wrap: got mode=%0d scale=%0d chg=%0b, want mode=%0d scale=%0d chg=%0b",
             tag, ifw.mode, ifw.scale, ifw.mode_chg, ew, exp_scale(ew), cw);
    end
    checks++;
    assert ({ifs.mode, ifs.scale, ifs.mode_chg} === {es, exp_scale(es), cs}) else begin
      errors++;
      $error("FAIL %s sat: got mode=%0d scale=%0d chg=%0b, want mode=%0d scale=%0d chg=%0b",
             tag, ifs.mode, ifs.scale, ifs.mode_chg, es, exp_scale(es), cs);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      chk(tag, 1'b0, 1'b0);
    end
  endtask

  task automatic press(input logic u, input logic d, input int n);
    btn_up = u;
    btn_dn = d;
    cyc(n);
  endtask

  // Release both buttons and expect the move exactly DEB_CYC+3 edges later.
  task automatic release_chk(input string tag, input logic [1:0] nw, input logic [1:0] ns);
    logic cw;
    logic cs;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    cyc(6);
    chk({tag, "_early"}, 1'b0, 1'b0);
    cyc(1);
    cw = (nw != ew);
    cs = (ns != es);
    ew = nw;
    es = ns;
    chk(tag, cw, cs);
    cyc(1);
    chk({tag, "_after"}, 1'b0, 1'b0);
  endtask

  initial begin
    ew = 2'd2;
    es = 2'd2;
    rst_n = 1'b0;
    cyc(2);
    chk("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    chk("reset_idle", 1'b0, 1'b0);

    press(1'b1, 1'b0, 10);
    release_chk("up1", 2'd3, 2'd3);

    // Reset while up is held; the held button counts as a fresh press.
    press(1'b1, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    ew = 2'd2;
    es = 2'd2;
    chk("reset_mid", 1'b0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    release_chk("up_after_rst", 2'd3, 2'd3);

    press(1'b1, 1'b0, 10);
    release_chk("up_wrap_sat", 2'd0, 2'd3);
    press(1'b1, 1'b0, 10);
    release_chk("up_to1", 2'd1, 2'd3);

    for (int i = 0; i < 16; i++) begin
      btn_up = ~btn_up;
      quiet("bounce", 2);
    end
    quiet("bounce_tail", 10);
    press(1'b1, 1'b0, 6);
    release_chk("clean6", 2'd2, 2'd3);
    press(1'b1, 1'b0, 10);
    release_chk("up_to3", 2'd3, 2'd3);

    btn_dn = 1'b1;
    cyc(26);
    chk("long_early", 1'b0, 1'b0);
    cyc(1);
    ew = 2'd0;
    es = 2'd0;
    chk("long", 1'b1, 1'b1);
    cyc(1);
    chk("long_after", 1'b0, 1'b0);
    cyc(12);
    btn_dn = 1'b0;
    quiet("long_rel", 12);

    btn_dn = 1'b1;
    cyc(27);
    chk("long_at0", 1'b0, 1'b0);
    cyc(13);
    btn_dn = 1'b0;
    quiet("long_at0_rel", 12);

    press(1'b0, 1'b1, 10);
    release_chk("dn_wrap_sat", 2'd3, 2'd0);

    press(1'b1, 1'b1, 10);
    release_chk("simul", 2'd3, 2'd0);

    btn_up = 1'b1;
    btn_dn = 1'b1;
    cyc(10);
    btn_up = 1'b0;
    cyc(1);
    btn_dn = 1'b0;
    cyc(5);
    chk("stag_early", 1'b0, 1'b0);
    cyc(1);
    ew = 2'd0;
    es = 2'd1;
    chk("stag_up", 1'b1, 1'b1);
    cyc(1);
    ew = 2'd3;
    es = 2'd0;
    chk("stag_dn", 1'b1, 1'b1);
    cyc(1);
    chk("stag_after", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/assist_mode_ctrl.md
# assist_mode_ctrl

Parametrised pedal-assist mode selector for the e-bike controller. It takes two raw push-buttons (up/down), synchronises and debounces them, and steps an assist-mode index on button release. A long press on the down button forces assist off. It maps the mode through a run-time scale table to the `scale` value consumed by the torque/assist datapath, and pulses `mode_chg` for the display/telemetry logic.

## Interface
- `NUM_MODES`, 4: number of assist modes, ≥ 2; `MW = $clog2(NUM_MODES)`.
- `SCALE_W`, 3: width of each scale entry.
- `RST_MODE`, 2: mode after reset; must be < `NUM_MODES`.
- `DEB_CYC`, 50000: cycles a synchronised input must be stable before the debounced level changes; ≥ 2.
- `LONG_CYC`, 1000000: debounced hold cycles on `btn_dn` that constitute a long press; > `DEB_CYC`.
- `WRAP`, 1: 1 = wrap at the ends; 0 = saturate.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low; clock `clk`.
- `btn_up`, input, 1: raw up button, active-high, asynchronous.
- `btn_dn`, input, 1: raw down button, active-high, asynchronous.
- `scale_tbl`, input, `NUM_MODES*SCALE_W`: entry *m* is at `[m*SCALE_W +: SCALE_W]`; quasi-static.
- `mode`, output, `MW`: current assist mode.
- `scale`, output, `SCALE_W`: `scale_tbl` entry selected by `mode`; combinational from `mode` and `scale_tbl`.
- `mode_chg`, output, 1: one-cycle pulse when `mode` changed value on the previous edge.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser. Synchroniser flops reset to 0.
- **Debouncer (per button).**
  - Counter `cnt` clears whenever the synchronised value `s` equals the debounced value `deb`.
  - Otherwise `cnt` increments.
  - When `cnt == DEB_CYC-1` and `s != deb`: `deb <= s` and `cnt <= 0`.
  - `deb` resets to 0.
- **Release event.** `rel = deb_q & ~deb`, where `deb_q` is `deb` delayed one cycle. It lasts exactly one cycle.
- **Long press (dn only).**
  - `hold` counts cycles while `deb_dn` is 1, saturating at `LONG_CYC`. It clears when `deb_dn` is 0.
  - `long_evt` asserts for one cycle when `hold` transitions to `LONG_CYC`. At the same time flag `long_seen` sets.
  - While `long_seen` is set, the next `rel_dn` is consumed with no mode action. `long_seen` clears on that release.
- **Mode update priority (one action per cycle):**
  1. `long_evt`: `mode <= 0`.
  2. `rel_up` and `rel_dn` in the same cycle (`rel_dn` not consumed): no change.
  3. `rel_up`: if `mode == NUM_MODES-1`, then `mode <= 0` when `WRAP`, else hold. Otherwise `mode + 1`.
  4. `rel_dn` (not consumed): if `mode == 0`, then `mode <= NUM_MODES-1` when `WRAP`, else hold. Otherwise `mode - 1`.
- **`mode_chg`.** Registered. It is 1 in the cycle after any edge where `mode` took a different value. Saturated-hold, long press at mode 0, and cancelled simultaneous releases produce no pulse.
- **Reset values.**
  - `mode = RST_MODE`, `scale = scale_tbl[RST_MODE]`, `mode_chg = 0`.
  - All counters and flags are 0.
- **Reset mid-press.** All state clears. A button still held at reset release is debounced as a fresh press, and its release acts normally.
- Changing `scale_tbl` affects `scale` combinationally and never affects `mode`.

## Timing
- Raw release first sampled at edge E1. `s` falls at E2. `deb` falls at E(`DEB_CYC`+2). `mode` updates at E(`DEB_CYC`+3). `mode_chg` is high for the following cycle.
- Glitches shorter than `DEB_CYC` cycles at `s` never change `deb`. Any mismatch-free cycle restarts the count.
- For a long press, `mode` goes to 0 `LONG_CYC`+1 edges after `deb_dn` rises, while the button is still held.
- No handshake: the consumer samples `mode` and `scale` at any time; both are glitch-free except for changes to `scale_tbl`.

## Test plan
Bench configuration: `NUM_MODES=4`, `RST_MODE=2`, `DEB_CYC=4`, `LONG_CYC=20`, `scale_tbl={3'd7,3'd5,3'd3,3'd0}`.

1. **Reset check.** Apply reset and check `mode=2`, `scale=5`, `mode_chg=0`. Assert `rst_n` low mid-count and check all outputs return to reset values.
2. **Short up presses.** Press/release `btn_up` (10-cycle press) 3 times. Expect the mode sequence 3, 0, 1, `scale` values 7, 0, 3, and `mode_chg` one cycle each. Check the update lands exactly `DEB_CYC`+3 edges after the release is sampled.
3. **Saturation.** With `WRAP=0`, from mode 3 release up, expect no change and no `mode_chg`. From mode 0 release down, expect the same.
4. **Bounce rejection.** Toggle `btn_up` every 2 cycles for 30 cycles and end low. Expect no mode change. Then apply a clean 6-cycle press: mode +1.
5. **Long press.** From mode 3, hold `btn_dn` for 40 cycles. Expect `mode=0` `LONG_CYC`+1 edges after `deb_dn` rises, with one `mode_chg`. On release, no further change. Repeat at mode 0: no pulse.
6. **Simultaneous release.** Release `btn_up` and `btn_dn` on the same cycle. Expect `mode` unchanged and no `mode_chg`. Releases one cycle apart give +1 then −1, with two pulses.
